// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_ctrl_pkg
//  Brief    : Shared AES control codes. The next-state logic and the round
//             sequencer both import these, so the two agree on state codes,
//             the round count and the counter width.
//  Revision : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

   // Control state codes carried on Q
   localparam logic [3:0] S0 = 4'd0;
   localparam logic [3:0] S1 = 4'd1;
   localparam logic [3:0] S2 = 4'd2;
   localparam logic [3:0] S3 = 4'd3;
   localparam logic [3:0] S4 = 4'd4;
   localparam logic [3:0] S5 = 4'd5;
   localparam logic [3:0] S6 = 4'd6;
   localparam logic [3:0] S7 = 4'd7;
   localparam logic [3:0] S8 = 4'd8;
   localparam logic [3:0] S9 = 4'd9;

   // AES-128 round count and round-counter width
   localparam int NR = 10;
   localparam int CW = 4;

   // Round counter operation selected by the state decode
   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_LOAD = 2'd1,
      CNT_UP   = 2'd2,
      CNT_DOWN = 2'd3
   } cnt_op_e;

   // True for the ten codes the control FSM actually uses
   function automatic logic is_state_code(input logic [3:0] q);
      return (q <= S9);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_cnt
//  Brief    : Loadable up/down round counter. Counting up stops at MAX_VAL,
//             counting down stops at MIN_VAL; neither direction wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_round_cnt
   import aes_ctrl_pkg::*;
#(
   parameter int W       = 4,
   parameter int MAX_VAL = 10,
   parameter int MIN_VAL = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  cnt_op_e      op,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_C = W'(MAX_VAL);
   localparam logic [W-1:0] MIN_C = W'(MIN_VAL);
   localparam logic [W-1:0] ONE_C = W'(1);

   // Counter register: load, saturating increment/decrement, or hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case (op)
            CNT_LOAD: count <= load_val;
            CNT_UP:   if (count < MAX_C) count <= count + ONE_C;
            CNT_DOWN: if (count > MIN_C) count <= count - ONE_C;
            default:  count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/aes_round_seq.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_seq
//  Brief    : Datapath-side responder to the AES control state Q. Owns the
//             round counter fed back to the next-state logic, derives the
//             round-key address and per-state datapath strobes, and runs the
//             host Busy/Done/Out_Valid handshake for encrypt and decrypt.
//  Options  : AES_ROUND_SEQ_ERR_EN adds a sticky Err output that flags
//             illegal state codes and counter misuse and then silences the
//             strobes, Busy and Done until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_round_seq #(
   parameter int NR = aes_ctrl_pkg::NR,
   parameter int CW = aes_ctrl_pkg::CW
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic [3:0]    Q,
   input  logic          Select,
   input  logic          Start,
   output logic [CW-1:0] Count,
   output logic [CW-1:0] Key_Addr,
   output logic          Load_In,
   output logic          Add_Key,
   output logic          Round_En,
   output logic          Final_Rnd,
   output logic          Inv,
   output logic          Busy,
   output logic          Done,
   output logic          Out_Valid
`ifdef AES_ROUND_SEQ_ERR_EN
   ,
   output logic          Err
`endif
);

   import aes_ctrl_pkg::*;

   localparam logic [CW-1:0] NR_C    = CW'(NR);
   localparam logic [CW-1:0] NR_M1_C = CW'(NR - 1);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic          accept;
   cnt_op_e       cnt_op;
   logic [CW-1:0] cnt_load;
   logic          busy_q;
   logic          done_q;
   logic          err_active;
   logic          load_in_d;
   logic          add_key_d;
   logic          round_en_d;
   logic          final_rnd_d;

   assign accept = (Q == S0) && Start;

   // Translate the state code into a counter operation
   always_comb begin
      cnt_op   = CNT_HOLD;
      cnt_load = '0;
      case (Q)
         S1: begin
            cnt_op   = CNT_LOAD;
            cnt_load = ONE_C;
         end
         S2: cnt_op = CNT_UP;
         S4: begin
            cnt_op   = CNT_LOAD;
            cnt_load = NR_C;
         end
         S5: begin
            cnt_op   = CNT_LOAD;
            cnt_load = NR_M1_C;
         end
         S6: cnt_op = CNT_DOWN;
         S0, S9: begin
            cnt_op   = CNT_LOAD;
            cnt_load = '0;
         end
         default: cnt_op = CNT_HOLD;
      endcase
   end

   aes_round_cnt #(
      .W       (CW),
      .MAX_VAL (NR),
      .MIN_VAL (1)
   ) u_round_cnt (
      .clk      (Clk),
      .rst_n    (Rst_n),
      .op       (cnt_op),
      .load_val (cnt_load),
      .count    (Count)
   );

   // Round-key index: the first key in S1, the last key around the decrypt
   // preamble, and the live round number while rounds are in progress
   always_comb begin
      Key_Addr = '0;
      case (Q)
         S2, S3, S6, S7: Key_Addr = Count;
         S4, S5:         Key_Addr = NR_C;
         S8:             Key_Addr = Inv ? '0 : Count;
         default:        Key_Addr = '0;
      endcase
   end

   // Per-state datapath strobes; Q itself resets to S0, so they idle low
   always_comb begin
      load_in_d   = 1'b0;
      add_key_d   = 1'b0;
      round_en_d  = 1'b0;
      final_rnd_d = 1'b0;
      case (Q)
         S1: begin
            load_in_d = 1'b1;
            add_key_d = 1'b1;
         end
         S2: begin
            round_en_d  = 1'b1;
            final_rnd_d = (Count == NR_C);
         end
         S3: final_rnd_d = 1'b1;
         S4: load_in_d = 1'b1;
         S5: add_key_d = 1'b1;
         S6: round_en_d = 1'b1;
         S7: add_key_d = 1'b1;
         default: load_in_d = 1'b0;
      endcase
   end

   assign Load_In   = load_in_d   & ~err_active;
   assign Add_Key   = add_key_d   & ~err_active;
   assign Round_En  = round_en_d  & ~err_active;
   assign Final_Rnd = final_rnd_d & ~err_active;

   // Host handshake: latch direction on accept, finish in S9. Done requires
   // an accepted request still in flight, so a second S9 cycle or an S9
   // reached after reset never produces a pulse.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Inv       <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         Out_Valid <= 1'b0;
      end else begin
         done_q <= (Q == S9) && busy_q;
         if (accept) begin
            Inv       <= Select;
            busy_q    <= 1'b1;
            Out_Valid <= 1'b0;
         end else if (Q == S9) begin
            busy_q    <= 1'b0;
            Out_Valid <= 1'b1;
         end
      end
   end

   assign Busy = busy_q & ~err_active;
   assign Done = done_q & ~err_active;

`ifdef AES_ROUND_SEQ_ERR_EN
   logic err_q;
   logic sat_q;

   // Sticky error: illegal code, a second saturated S2 cycle, or S6 at zero
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         err_q <= 1'b0;
         sat_q <= 1'b0;
      end else begin
         sat_q <= (Q == S2) && (Count == NR_C);
         err_q <= err_q
                | ~is_state_code(Q)
                | ((Q == S2) && (Count == NR_C) && sat_q)
                | ((Q == S6) && (Count == '0));
      end
   end

   assign err_active = err_q;
   assign Err        = err_q;
`else
   assign err_active = 1'b0;
`endif

endmodule
`default_nettype wire
